dmem_unit: RTL and testbench

- Data-memory stage sitting directly downstream of the pipelined CPU's EX/MEM register.
- Consumes the CPU's address, store data, write strobe, access type and read strobe; returns load data combinationally within the same cycle, so the MEM/WB register samples it on the next rising edge.
- Provides byte/halfword/word access with load sign/zero extension, a small MMIO window (output register, synchronised input port, load/store counters) and sticky misalignment error capture.

---
 rtl/dmem_if.sv | 12 +
 rtl/dmem_unit.sv | 141 ++++++++++++++
 tb/tb_dmem_unit.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// CPU-side data-memory bus: EX/MEM request fields in, extended load data back out.
interface dmem_if;
  logic        mem_w;
  logic        mem_r;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  dm_type;
  logic [31:0] rdata;

  modport master (output mem_w, mem_r, addr, wdata, dm_type, input rdata);
  modport slave  (input mem_w, mem_r, addr, wdata, dm_type, output rdata);
endinterface

// File: rtl/dmem_unit.sv
// Data-memory stage: byte/half/word RAM with combinational load path, a 16-byte MMIO
// window (io_out, synchronised io_in, load/store counters) and sticky misalignment capture.
module dmem_unit #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
  parameter bit          INIT_ZERO  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  dmem_if.slave       bus,
  input  logic [31:0] io_in,
  output logic [31:0] io_out,
  output logic        err_misalign,
  output logic [31:0] err_addr
);

  localparam int unsigned RamDepth = 2 ** ADDR_WIDTH;

  localparam logic [2:0] TyWord  = 3'd0;
  localparam logic [2:0] TyHalfS = 3'd1;
  localparam logic [2:0] TyHalfU = 3'd2;
  localparam logic [2:0] TyByteS = 3'd3;
  localparam logic [2:0] TyByteU = 3'd4;

  logic [31:0] ram_q [RamDepth] = '{default: (INIT_ZERO ? 32'h0 : 32'hx)};

  logic [31:0] io_out_q, io_out_d;
  logic [31:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [31:0] load_cnt_q, load_cnt_d, store_cnt_q, store_cnt_d;
  logic        err_misalign_q, err_misalign_d;
  logic [31:0] err_addr_q, err_addr_d;

  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  mmio_hit, aligned, fault, store_ok, ram_we, cnt_clr;
  logic [3:0]            be;
  logic [31:0]           st_data, rd_word, rd_shift;

  always_comb begin
    word_idx = bus.addr[ADDR_WIDTH+1:2];
    mmio_hit = (bus.addr[31:4] == MMIO_BASE[31:4]);
    aligned  = 1'b0;
    be       = 4'b0000;
    st_data  = bus.wdata;
    case (bus.dm_type)
      TyWord: begin
        aligned = (bus.addr[1:0] == 2'b00);
        be      = 4'b1111;
      end
      TyHalfS, TyHalfU: begin
        aligned = ~bus.addr[0];
        be      = bus.addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{bus.wdata[15:0]}};
      end
      TyByteS, TyByteU: begin
        aligned = 1'b1;
        be      = 4'b0001 << bus.addr[1:0];
        st_data = {4{bus.wdata[7:0]}};
      end
      default: ;
    endcase
    fault    = (bus.mem_r | bus.mem_w) & ~aligned;
    store_ok = bus.mem_w & aligned;
    // Reset drops the RAM write too; RAM itself is never cleared.
    ram_we   = store_ok & ~mmio_hit & ~reset;
    cnt_clr  = store_ok & mmio_hit & (bus.addr[3:2] == 2'd2);
  end

  // Load path: pick the word, shift the addressed lane(s) down, then extend.
  always_comb begin
    rd_word = ram_q[word_idx];
    if (mmio_hit) begin
      case (bus.addr[3:2])
        2'd0:    rd_word = io_out_q;
        2'd1:    rd_word = sync2_q;
        2'd2:    rd_word = load_cnt_q;
        default: rd_word = store_cnt_q;
      endcase
    end
    rd_shift = rd_word >> {bus.addr[1:0], 3'b000};
    case (bus.dm_type)
      TyWord:  bus.rdata = rd_word;
      TyHalfS: bus.rdata = {{16{rd_shift[15]}}, rd_shift[15:0]};
      TyHalfU: bus.rdata = {16'h0, rd_shift[15:0]};
      TyByteS: bus.rdata = {{24{rd_shift[7]}}, rd_shift[7:0]};
      TyByteU: bus.rdata = {24'h0, rd_shift[7:0]};
      default: bus.rdata = 32'h0;
    endcase
    if (!aligned) bus.rdata = 32'h0;
  end

  always_comb begin
    io_out_d = io_out_q;
    if (store_ok && mmio_hit && (bus.addr[3:2] == 2'd0)) begin
      for (int n = 0; n < 4; n++) begin
        if (be[n]) io_out_d[8*n +: 8] = st_data[8*n +: 8];
      end
    end
    sync1_d = io_in;
    sync2_d = sync1_q;
    // A simultaneous store suppresses the load count.
    load_cnt_d  = load_cnt_q + 32'(bus.mem_r & aligned & ~bus.mem_w);
    store_cnt_d = store_cnt_q + 32'(store_ok);
    if (cnt_clr) begin
      load_cnt_d  = 32'h0;
      store_cnt_d = 32'h0;
    end
    err_misalign_d = err_misalign_q | fault;
    err_addr_d     = (fault && !err_misalign_q) ? bus.addr : err_addr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      io_out_q       <= 32'h0;
      sync1_q        <= 32'h0;
      sync2_q        <= 32'h0;
      load_cnt_q     <= 32'h0;
      store_cnt_q    <= 32'h0;
      err_misalign_q <= 1'b0;
      err_addr_q     <= 32'h0;
    end else begin
      io_out_q       <= io_out_d;
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      load_cnt_q     <= load_cnt_d;
      store_cnt_q    <= store_cnt_d;
      err_misalign_q <= err_misalign_d;
      err_addr_q     <= err_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (ram_we && be[n]) ram_q[word_idx][8*n +: 8] <= st_data[8*n +: 8];
    end
  end

  assign io_out       = io_out_q;
  assign err_misalign = err_misalign_q;
  assign err_addr     = err_addr_q;

endmodule

// File: tb/tb_dmem_unit.sv
// Directed bench for dmem_unit: one task per feature, hand-computed expectations.
module tb_dmem_unit;
  localparam logic [31:0] Base = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] io_in;
  logic [31:0] io_out;
  logic        err_misalign;
  logic [31:0] err_addr;
  int          checks = 0;
  int          passes = 0;

  dmem_if bus ();

  dmem_unit #(.ADDR_WIDTH(10), .MMIO_BASE(Base), .INIT_ZERO(1'b1)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .io_in        (io_in),
    .io_out       (io_out),
    .err_misalign (err_misalign),
    .err_addr     (err_addr)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] t);
    bus.mem_w   = w;
    bus.mem_r   = r;
    bus.addr    = a;
    bus.wdata   = d;
    bus.dm_type = t;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(1, 0, 32'h40, 32'h1111_1111, 3'd0);
    tick;
    tick;
    reset = 1'b0;
    drive(0, 0, 32'h0, 32'h0, 3'd0);
    checks++; if (io_out !== 32'h0) $display("FAIL reset_io_out got %h exp 0", io_out); else passes++;
    checks++; if (err_misalign !== 1'b0) $display("FAIL reset_err got %b exp 0", err_misalign); else passes++;
    checks++; if (err_addr !== 32'h0) $display("FAIL reset_err_addr got %h exp 0", err_addr); else passes++;
    drive(0, 1, Base + 32'h8, 32'h0, 3'd0);
    checks++; if (bus.rdata !== 32'h0) $display("FAIL reset_load_cnt got %h exp 0", bus.rdata); else passes++;
    drive(0, 1, Base + 32'hC, 32'h0, 3'd0);
    checks++; if (bus.rdata !== 32'h0) $display("FAIL reset_store_cnt got %h exp 0", bus.rdata); else passes++;
    drive(0, 1, 32'h40, 32'h0, 3'd0);
    checks++; if (bus.rdata !== 32'h0) $display("FAIL reset_store_dropped got %h exp 0", bus.rdata); else passes++;
    tick;
  endtask

  task automatic test_word;
    drive(1, 0, Base + 32'h8, 32'h0, 3'd0);
    tick;
    drive(1, 0, 32'h100, 32'hDEAD_BEEF, 3'd0);
    tick;
    drive(0, 1, 32'h100, 32'h0, 3'd0);
    checks++; if (bus.rdata !== 32'hDEAD_BEEF) $display("FAIL word_load got %h exp deadbeef", bus.rdata); else passes++;
    tick;
    drive(0, 1, Base + 32'hC, 32'h0, 3'd0);
    checks++; if (bus.rdata !== 32'h1) $display("FAIL word_store_cnt got %h exp 1", bus.rdata); else passes++;
    drive(0, 1, Base + 32'h8, 32'h0, 3'd0);
    checks++; if (bus.rdata !== 32'h1) $display("FAIL word_load_cnt got %h exp 1", bus.rdata); else passes++;
    tick;
  endtask

  task automatic test_lanes;
    drive(1, 0, 32'h200, 32'h80FF_7F01, 3'd0);
    tick;
    drive(0, 1, 32'h201, 32'h0, 3'd3);
    checks++; if (bus.rdata !== 32'h0000_007F) $display("FAIL lb_201 got %h exp 0000007f", bus.rdata); else passes++;
    drive(0, 1, 32'h202, 32'h0, 3'd3);
    checks++; if (bus.rdata !== 32'hFFFF_FFFF) $display("FAIL lb_202 got %h exp ffffffff", bus.rdata); else passes++;
    drive(0, 1, 32'h202, 32'h0, 3'd4);
    checks++; if (bus.rdata !== 32'h0000_00FF) $display("FAIL lbu_202 got %h exp 000000ff", bus.rdata); else passes++;
    drive(0, 1, 32'h203, 32'h0, 3'd4);
    checks++; if (bus.rdata !== 32'h0000_0080) $display("FAIL lbu_203 got %h exp 00000080", bus.rdata); else passes++;
    drive(0, 1, 32'h202, 32'h0, 3'd1);
    checks++; if (bus.rdata !== 32'hFFFF_80FF) $display("FAIL lh_202 got %h exp ffff80ff", bus.rdata); else passes++;
    drive(0, 1, 32'h200, 32'h0, 3'd2);
    checks++; if (bus.rdata !== 32'h0000_7F01) $display("FAIL lhu_200 got %h exp 00007f01", bus.rdata); else passes++;
    tick;
  endtask

  task automatic test_half_rdw;
    drive(1, 0, Base + 32'h8, 32'h0, 3'd0);
    tick;
    drive(1, 1, 32'h302, 32'hABCD_1234, 3'd2);
    checks++; if (bus.rdata !== 32'h0) $display("FAIL rdw_old got %h exp 0", bus.rdata); else passes++;
    tick;
    drive(0, 1, 32'h300, 32'h0, 3'd0);
    checks++; if (bus.rdata !== 32'h1234_0000) $display("FAIL half_store got %h exp 12340000", bus.rdata); else passes++;
    drive(0, 1, Base + 32'hC, 32'h0, 3'd0);
    checks++; if (bus.rdata !== 32'h1) $display("FAIL both_store_cnt got %h exp 1", bus.rdata); else passes++;
    drive(0, 1, Base + 32'h8, 32'h0, 3'd0);
    checks++; if (bus.rdata !== 32'h0) $display("FAIL both_load_cnt got %h exp 0", bus.rdata); else passes++;
    tick;
  endtask

  task automatic test_mmio;
    drive(1, 0, Base + 32'h1, 32'h1234_56AA, 3'd3);
    tick;
    checks++; if (io_out !== 32'h0000_AA00) $display("FAIL io_out_byte got %h exp 0000aa00", io_out); else passes++;
    drive(0, 1, Base + 32'h1, 32'h0, 3'd4);
    checks++; if (bus.rdata !== 32'h0000_00AA) $display("FAIL io_out_read got %h exp 000000aa", bus.rdata); else passes++;
    drive(1, 0, Base + 32'h2, 32'h0000_BEEF, 3'd1);
    tick;
    checks++; if (io_out !== 32'hBEEF_AA00) $display("FAIL io_out_half got %h exp beefaa00", io_out); else passes++;
    io_in = 32'h5;
    drive(0, 1, Base + 32'h4, 32'h0, 3'd0);
    checks++; if (bus.rdata !== 32'h0) $display("FAIL io_in_edge0 got %h exp 0", bus.rdata); else passes++;
    tick;
    checks++; if (bus.rdata !== 32'h0) $display("FAIL io_in_edge1 got %h exp 0", bus.rdata); else passes++;
    tick;
    checks++; if (bus.rdata !== 32'h5) $display("FAIL io_in_edge2 got %h exp 5", bus.rdata); else passes++;
    drive(1, 0, Base + 32'h4, 32'hFFFF_FFFF, 3'd0);
    tick;
    checks++; if (io_out !== 32'hBEEF_AA00) $display("FAIL io_in_store got %h exp beefaa00", io_out); else passes++;
    drive(1, 0, Base + 32'h8, 32'h0, 3'd0);
    tick;
    drive(0, 1, Base + 32'h8, 32'h0, 3'd0);
    checks++; if (bus.rdata !== 32'h0) $display("FAIL clr_load_cnt got %h exp 0", bus.rdata); else passes++;
    drive(0, 1, Base + 32'hC, 32'h0, 3'd0);
    checks++; if (bus.rdata !== 32'h0) $display("FAIL clr_store_cnt got %h exp 0", bus.rdata); else passes++;
    tick;
  endtask

  task automatic test_misalign;
    drive(1, 0, 32'h104, 32'hCAFE_F00D, 3'd0);
    tick;
    drive(1, 0, 32'h105, 32'h1122_3344, 3'd0);
    tick;
    checks++; if (err_misalign !== 1'b1) $display("FAIL mis_flag got %b exp 1", err_misalign); else passes++;
    checks++; if (err_addr !== 32'h105) $display("FAIL mis_addr got %h exp 105", err_addr); else passes++;
    drive(0, 1, 32'h104, 32'h0, 3'd0);
    checks++; if (bus.rdata !== 32'hCAFE_F00D) $display("FAIL mis_nowrite got %h exp cafef00d", bus.rdata); else passes++;
    drive(0, 1, 32'h106, 32'h0, 3'd0);
    checks++; if (bus.rdata !== 32'h0) $display("FAIL mis_load got %h exp 0", bus.rdata); else passes++;
    tick;
    drive(1, 0, 32'h107, 32'h0000_5555, 3'd1);
    tick;
    checks++; if (err_addr !== 32'h105) $display("FAIL mis_sticky got %h exp 105", err_addr); else passes++;
    drive(0, 1, 32'h104, 32'h0, 3'd5);
    checks++; if (bus.rdata !== 32'h0) $display("FAIL bad_type got %h exp 0", bus.rdata); else passes++;
    drive(0, 0, 32'h0, 32'h0, 3'd0);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checks++; if (err_misalign !== 1'b0) $display("FAIL rst_flag got %b exp 0", err_misalign); else passes++;
    checks++; if (err_addr !== 32'h0) $display("FAIL rst_addr got %h exp 0", err_addr); else passes++;
    checks++; if (io_out !== 32'h0) $display("FAIL rst_io_out got %h exp 0", io_out); else passes++;
    drive(0, 1, Base + 32'h4, 32'h0, 3'd0);
    checks++; if (bus.rdata !== 32'h0) $display("FAIL rst_sync got %h exp 0", bus.rdata); else passes++;
    drive(0, 1, 32'h104, 32'h0, 3'd0);
    checks++; if (bus.rdata !== 32'hCAFE_F00D) $display("FAIL rst_ram_kept got %h exp cafef00d", bus.rdata); else passes++;
    tick;
  endtask

  task automatic test_wrap;
    drive(1, 0, 32'h1000, 32'h1357_9BDF, 3'd0);
    tick;
    drive(0, 1, 32'h0, 32'h0, 3'd0);
    checks++; if (bus.rdata !== 32'h1357_9BDF) $display("FAIL wrap got %h exp 13579bdf", bus.rdata); else passes++;
    tick;
    drive(0, 0, 32'h0, 32'h0, 3'd0);
  endtask

  initial begin
    io_in = 32'h0;
    test_reset;
    test_word;
    test_lanes;
    test_half_rdw;
    test_mmio;
    test_misalign;
    test_wrap;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
